// File: rtl/dot_product_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dot_product_arbiter
// Purpose  : Round-robin sharing of one neg_dot_product pipeline, with ID
//            tracking and a credit-protected response FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module dot_product_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DP_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*26-1:0]   req_unit_x,
    input  logic [NUM_REQ*26-1:0]   req_unit_y,
    input  logic [NUM_REQ*26-1:0]   req_unit_z,
    input  logic [NUM_REQ*24-1:0]   req_x2,
    input  logic [NUM_REQ*24-1:0]   req_y2,
    input  logic [NUM_REQ*24-1:0]   req_z2,
    output logic [25:0]             dp_unit_x,
    output logic [25:0]             dp_unit_y,
    output logic [25:0]             dp_unit_z,
    output logic [23:0]             dp_x2,
    output logic [23:0]             dp_y2,
    output logic [23:0]             dp_z2,
    input  logic [23:0]             dp_out,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [23:0]             rsp_data,
    output logic                    busy
);

    localparam int ID_W      = $clog2(NUM_REQ);
    localparam int c_IDX_W   = ID_W + 1;
    localparam int c_UNIT_W  = 26;
    localparam int c_SQ_W    = 24;
    localparam int c_DATA_W  = 24;
    localparam int c_ENTRY_W = ID_W + c_DATA_W;
    localparam int c_PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int c_IF_W    = $clog2(DP_LAT + 1);
    localparam int c_SUM_W   = c_CNT_W + 1;

    localparam logic [c_IDX_W-1:0] c_NUM_REQ_X = c_IDX_W'(NUM_REQ);
    localparam logic [ID_W-1:0]    c_LAST_ID   = ID_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] c_ONE       = NUM_REQ'(1);
    localparam logic [c_SUM_W-1:0] c_DEPTH_S   = c_SUM_W'(FIFO_DEPTH);
    localparam logic [c_CNT_W-1:0] c_DEPTH_C   = c_CNT_W'(FIFO_DEPTH);

    logic [ID_W-1:0]      r_rr_ptr;
    logic [DP_LAT-1:0]    r_tag_v;
    logic [ID_W-1:0]      r_tag_id [DP_LAT];
    logic [c_IF_W-1:0]    r_inflight;
    logic [c_CNT_W-1:0]   r_count;
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_ENTRY_W-1:0] r_mem [FIFO_DEPTH];

    logic                 w_issue_ok;
    logic                 w_found;
    logic [ID_W-1:0]      w_grant_id;
    logic [c_IDX_W-1:0]   w_idx;
    logic                 w_transfer;
    logic [ID_W-1:0]      w_mux_id;
    logic [c_SUM_W-1:0]   w_credit_sum;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_empty;
    logic                 w_full;

    // Credits come from registered counts only, so a pop frees a slot next cycle.
    assign w_credit_sum = c_SUM_W'(r_inflight) + c_SUM_W'(r_count);
    assign w_issue_ok   = rst_n && enable && (w_credit_sum < c_DEPTH_S);

    always_comb begin
        w_found    = 1'b0;
        w_grant_id = r_rr_ptr;
        w_idx      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = {1'b0, r_rr_ptr} + c_IDX_W'(k);
            if (w_idx >= c_NUM_REQ_X) begin
                w_idx = w_idx - c_NUM_REQ_X;
            end
            if (!w_found && req_valid[w_idx[ID_W-1:0]]) begin
                w_found    = 1'b1;
                w_grant_id = w_idx[ID_W-1:0];
            end
        end
    end

    assign w_transfer = w_issue_ok && w_found;
    assign req_ready  = w_transfer ? (c_ONE << w_grant_id) : '0;
    assign w_mux_id   = w_transfer ? w_grant_id : r_rr_ptr;

    assign dp_unit_x = req_unit_x[c_UNIT_W*w_mux_id +: c_UNIT_W];
    assign dp_unit_y = req_unit_y[c_UNIT_W*w_mux_id +: c_UNIT_W];
    assign dp_unit_z = req_unit_z[c_UNIT_W*w_mux_id +: c_UNIT_W];
    assign dp_x2     = req_x2[c_SQ_W*w_mux_id +: c_SQ_W];
    assign dp_y2     = req_y2[c_SQ_W*w_mux_id +: c_SQ_W];
    assign dp_z2     = req_z2[c_SQ_W*w_mux_id +: c_SQ_W];

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_DEPTH_C);
    assign w_push  = r_tag_v[DP_LAT-1];
    assign w_pop   = !w_empty && rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr   <= '0;
            r_tag_v    <= '0;
            r_inflight <= '0;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            for (int k = 0; k < DP_LAT; k++) begin
                r_tag_id[k] <= '0;
            end
        end else begin
            if (w_transfer) begin
                r_rr_ptr <= (w_grant_id == c_LAST_ID) ? '0 : w_grant_id + 1'b1;
            end
            r_tag_v[0]  <= w_transfer;
            r_tag_id[0] <= w_grant_id;
            for (int k = 1; k < DP_LAT; k++) begin
                r_tag_v[k]  <= r_tag_v[k-1];
                r_tag_id[k] <= r_tag_id[k-1];
            end
            case ({w_transfer, w_push})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Storage needs no reset: the head is masked to zero whenever empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {r_tag_id[DP_LAT-1], dp_out};
        end
    end

    assign rsp_valid = !w_empty;
    assign rsp_id    = w_empty ? '0 : r_mem[r_rd_ptr][c_ENTRY_W-1:c_DATA_W];
    assign rsp_data  = w_empty ? '0 : r_mem[r_rd_ptr][c_DATA_W-1:0];
    assign busy      = (r_inflight != '0) || !w_empty;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_push && !w_pop && w_full));

endmodule
`default_nettype wire

// File: tb/tb_dot_product_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_dot_product_arbiter
// Purpose  : Directed and random stimulus against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dot_product_arbiter;

    localparam int N     = 4;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              enable;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*26-1:0]   req_unit_x, req_unit_y, req_unit_z;
    logic [N*24-1:0]   req_x2, req_y2, req_z2;
    logic [25:0]       dp_unit_x, dp_unit_y, dp_unit_z;
    logic [23:0]       dp_x2, dp_y2, dp_z2;
    logic [23:0]       dp_out;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_id;
    logic [23:0]       rsp_data;
    logic              busy;

    logic [25:0] op_ux [N];
    logic [25:0] op_uy [N];
    logic [25:0] op_uz [N];
    logic [23:0] op_x2 [N];
    logic [23:0] op_y2 [N];
    logic [23:0] op_z2 [N];

    typedef struct {int id; logic [23:0] data; int t;} fl_t;
    typedef struct {int id; logic [23:0] data;} rs_t;
    fl_t m_fl[$];
    rs_t m_q[$];
    int  m_ptr = 0;
    int  m_out = 0;
    int  cyc   = 0;
    int  total = 0;
    int  bad   = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < N; k++) begin
            req_unit_x[26*k +: 26] = op_ux[k];
            req_unit_y[26*k +: 26] = op_uy[k];
            req_unit_z[26*k +: 26] = op_uz[k];
            req_x2[24*k +: 24]     = op_x2[k];
            req_y2[24*k +: 24]     = op_y2[k];
            req_z2[24*k +: 24]     = op_z2[k];
        end
    end

    // -(u . v2): 2Q24 x 4Q20 gives Q44, scaled down to 7Q17.
    function automatic logic [23:0] neg_dot(input logic [25:0] ux, uy, uz,
                                            input logic [23:0] x2, y2, z2);
        longint s;
        s = longint'($signed(ux)) * longint'($signed(x2))
          + longint'($signed(uy)) * longint'($signed(y2))
          + longint'($signed(uz)) * longint'($signed(z2));
        s = -s;
        s = s >>> 27;
        return s[23:0];
    endfunction

    // Stand-in for the shared pipeline: DP_LAT registers, first captures on the issue edge.
    logic [23:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= neg_dot(dp_unit_x, dp_unit_y, dp_unit_z, dp_x2, dp_y2, dp_z2);
        for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign dp_out = pipe[LAT-1];

    dot_product_arbiter #(.NUM_REQ(N), .DP_LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_unit_x(req_unit_x), .req_unit_y(req_unit_y), .req_unit_z(req_unit_z),
        .req_x2(req_x2), .req_y2(req_y2), .req_z2(req_z2),
        .dp_unit_x(dp_unit_x), .dp_unit_y(dp_unit_y), .dp_unit_z(dp_unit_z),
        .dp_x2(dp_x2), .dp_y2(dp_y2), .dp_z2(dp_z2), .dp_out(dp_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .busy(busy)
    );

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rand_ops();
        for (int k = 0; k < N; k++) begin
            op_ux[k] = 26'($urandom);
            op_uy[k] = 26'($urandom);
            op_uz[k] = 26'($urandom);
            op_x2[k] = 24'($urandom);
            op_y2[k] = 24'($urandom);
            op_z2[k] = 24'($urandom);
        end
    endtask

    // One clock: check outputs against the model, then advance the model across the edge.
    task automatic step();
        int           grant;
        logic [N-1:0] exp_ready;
        bit           xfer, pop;
        logic [23:0]  xdata;
        #1;
        grant = -1;
        xdata = '0;
        if (enable && m_out < DEPTH) begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_ptr + k) % N;
                if (grant < 0 && req_valid[idx]) grant = idx;
            end
        end
        xfer      = (grant >= 0);
        exp_ready = xfer ? (N'(1) << grant) : '0;
        chk("req_ready", req_ready, exp_ready);
        chk("rsp_valid", rsp_valid, m_q.size() > 0);
        chk("busy", busy, m_out != 0);
        if (m_q.size() > 0) begin
            chk("rsp_id", rsp_id, m_q[0].id);
            chk("rsp_data", rsp_data, m_q[0].data);
        end else begin
            chk("rsp_id_idle", rsp_id, 0);
            chk("rsp_data_idle", rsp_data, 0);
        end
        if (xfer) begin
            chk("dp_operands", {dp_unit_x, dp_unit_y, dp_unit_z, dp_x2, dp_y2, dp_z2},
                {op_ux[grant], op_uy[grant], op_uz[grant], op_x2[grant], op_y2[grant], op_z2[grant]});
            xdata = neg_dot(op_ux[grant], op_uy[grant], op_uz[grant],
                            op_x2[grant], op_y2[grant], op_z2[grant]);
        end
        pop = (m_q.size() > 0) && rsp_ready;
        @(posedge clk);
        cyc++;
        if (pop) void'(m_q.pop_front());
        if (m_fl.size() > 0 && m_fl[0].t + LAT == cyc) begin
            m_q.push_back('{id: m_fl[0].id, data: m_fl[0].data});
            void'(m_fl.pop_front());
        end
        if (xfer) begin
            m_fl.push_back('{id: grant, data: xdata, t: cyc});
            m_ptr = (grant + 1) % N;
            m_out++;
        end
        if (pop) m_out--;
        @(negedge clk);
    endtask

    // Asynchronous reset mid-cycle; outputs must clear without waiting for a clock.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_busy", busy, 0);
        m_fl.delete();
        m_q.delete();
        m_ptr = 0;
        m_out = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic idle(input int n);
        req_valid = '0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst_n     = 1'b1;
        enable    = 1'b0;
        rsp_ready = 1'b0;
        req_valid = '0;
        for (int k = 0; k < N; k++) begin
            op_ux[k] = '0; op_uy[k] = '0; op_uz[k] = '0;
            op_x2[k] = '0; op_y2[k] = '0; op_z2[k] = '0;
        end
        @(negedge clk);
        req_valid = '1;
        do_reset();

        // Single operation from requester 2: 1.0 * 2.0 negated
        req_valid = '0;
        op_ux[2]  = 26'h1000000;
        op_x2[2]  = 24'h200000;
        enable    = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 4'b0100;
        step();
        req_valid = '0;
        step();
        step();
        #1;
        chk("single_valid", rsp_valid, 1);
        chk("single_id", rsp_id, 2);
        chk("single_data", rsp_data, 24'hFC0000);
        step();
        #1;
        chk("single_busy_after_pop", busy, 0);

        // Fairness with continuous requests and a free consumer
        req_valid = '1;
        for (int i = 0; i < 16; i++) begin
            rand_ops();
            step();
        end
        idle(6);

        // Backpressure: fill credits, then drain and resume
        rsp_ready = 1'b0;
        req_valid = '1;
        for (int i = 0; i < 8; i++) begin
            rand_ops();
            step();
        end
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rand_ops();
            step();
        end
        idle(6);

        // Random traffic with intermittent consumer and enable
        for (int i = 0; i < 300; i++) begin
            rand_ops();
            req_valid = N'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            enable    = ($urandom_range(0, 7) != 0);
            step();
        end
        enable    = 1'b1;
        rsp_ready = 1'b1;
        idle(8);

        // enable low blocks grants while earlier results still drain
        rsp_ready = 1'b0;
        req_valid = '1;
        rand_ops();
        step();
        step();
        enable = 1'b0;
        for (int i = 0; i < 4; i++) step();
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        enable = 1'b1;
        idle(6);

        // Reset with operations in flight: nothing stale may emerge
        rsp_ready = 1'b0;
        req_valid = '1;
        rand_ops();
        step();
        step();
        do_reset();
        rsp_ready = 1'b1;
        idle(6);
        req_valid = 4'b1000;
        rand_ops();
        step();
        idle(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/dot_product_arbiter.md
Name: dot_product_arbiter

Overview:
- Shares one neg_dot_product pipeline among NUM_REQ requesters, e.g. the ray-setup, lighting and culling units.
- Arbitrates round-robin and drives operands into the shared pipeline.
- Tracks each issued operation's requester ID through the fixed pipeline latency.
- Buffers results in a credit-protected response FIFO, so downstream backpressure never loses a result from the free-running pipeline.

Parameters:
- NUM_REQ, 4, number of requesters (2..8); ID_W = clog2(NUM_REQ), derived localparam.
- DP_LAT, 2, cycles from the operand-sampling edge to dp_out valid.
- FIFO_DEPTH, 4, response FIFO entries (power of two, >= DP_LAT).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- enable  in  1  grants permitted when high
- req_valid  in  NUM_REQ  per-requester request
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
- req_unit_x/y/z  in  NUM_REQ*26 each  2Q24 operands, requester i at bits [26i+25:26i]
- req_x2/y2/z2  in  NUM_REQ*24 each  4Q20 operands, requester i at bits [24i+23:24i]
- dp_unit_x/y/z  out  26 each  to the shared pipeline
- dp_x2/y2/z2  out  24 each  to the shared pipeline
- dp_out  in  24  7Q17 result from the shared pipeline
- rsp_valid  out  1  FIFO head valid
- rsp_ready  in  1  consumer accept
- rsp_id  out  ID_W  requester of the head result
- rsp_data  out  24  7Q17 head result, passed through unmodified
- busy  out  1  in-flight or buffered work exists

Behaviour:
- Reset (rst_n low, asynchronous): rr_ptr=0, all tag-pipe valids=0, FIFO empty, inflight=0. Outputs: req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0.
- Reset mid-operation: in-flight operations are discarded. dp_out is ignored until new tags arrive.
- issue_ok = enable && (inflight + fifo_count < FIFO_DEPTH), computed from registered counts only. A same-cycle pop does not free a credit until the next cycle.
- Arbitration: pick the first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... with wrap mod NUM_REQ.
  - If issue_ok, req_ready[i]=1 for that i only.
  - req_ready is combinational and never depends on rsp_ready.
- Transfer: req_valid[i] && req_ready[i].
  - On transfer, rr_ptr <= (i+1) mod NUM_REQ.
  - With no transfer, rr_ptr holds.
- dp_* outputs combinationally mux the granted requester's operands. With no grant they hold the operands of the rr_ptr requester; their value is irrelevant because the tag is invalid.
- Tag pipe: DP_LAT stages of {valid, id}.
  - Stage 0 loads {transfer, i} each cycle.
  - On the cycle the last stage is valid, dp_out and its id are pushed into the FIFO.
- inflight counter: +1 on transfer, -1 on push; both in the same cycle nets 0. Range 0..DP_LAT.
- FIFO:
  - rsp_valid = !empty; rsp_id/rsp_data show the head entry.
  - Pop on rsp_valid && rsp_ready.
  - Simultaneous push and pop is legal at any occupancy, including full.
  - Push on full without pop is impossible by credit construction; an assertion fires if it occurs.
  - Pointers wrap mod FIFO_DEPTH.
- Throughput: one issue per cycle while credits remain. Minimum request-to-rsp_valid latency is DP_LAT+1 cycles: transfer edge + DP_LAT, then FIFO registered.
- enable deassert: no new grants. In-flight operations complete and stay drainable.
- busy = (inflight != 0) || !empty.

Test Plan:
- Single op: requester 2 sends unit_x=0x1000000 (1.0), x2=0x200000 (2.0), other operands 0, rsp_ready=1 -> rsp_valid 3 cycles after the transfer edge, rsp_id=2, rsp_data=0xFC0000 (-2.0 7Q17); busy low the cycle after the pop.
- Fairness: all 4 requesters valid continuously, rsp_ready=1 -> grants 0,1,2,3,0,1,...; one issue per cycle; each rsp_id matches its grant order.
- Backpressure: rsp_ready=0, all requesters valid -> exactly 4 transfers, then req_ready=0. Raising rsp_ready drains results in order, and issuing resumes one cycle after the first pop.
- Full with simultaneous push/pop: FIFO at 4 entries with rsp_ready=1 -> no overflow, no result lost, no assertion.
- Reset mid-flight: assert rst_n low with 2 operations in flight -> all outputs 0 immediately. After release, no stale rsp_valid appears.
- enable=0 with requesters valid -> req_ready=0; previously issued results still appear.
